hamming_encode: RTL and testbench

- Streaming single-error-correcting Hamming encoder; the transmit-side counterpart of the team's `decode` block.
- Takes 16-bit data words over a valid/ready handshake and emits 21-bit codewords that `decode` corrects and returns unchanged.
- Includes a 2-entry output buffer for full throughput under backpressure.
- Includes a single-bit error-injection port so decoder benches and link tests can corrupt codewords deliberately.

---
 rtl/hamming_encode.sv | 114 +++++++++++
 tb/tb_hamming_encode.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/hamming_encode.sv
// Streaming SEC Hamming encoder with a 2-entry output buffer and single-bit
// error injection, feeding the team's decode block.
module hamming_encode #(
   parameter int data_width     = 16,
   parameter int encoding_width = 21,
   parameter int pos_width      = 5
) (
   input  logic                      clk,
   input  logic                      rstb,
   input  logic [data_width-1:0]     raw_data,
   input  logic                      raw_valid,
   output logic                      raw_ready,
   input  logic                      inj_en,
   input  logic [pos_width-1:0]      inj_pos,
   output logic [encoding_width-1:0] encoded_data,
   output logic                      valid,
   input  logic                      ready,
   output logic [15:0]               word_count
);

   function automatic int calc_p(input int dw);
      int p;
      p = 0;
      while ((1 << p) < dw + p + 1) p++;
      return p;
   endfunction

   if (encoding_width != data_width + calc_p(data_width)) begin : g_bad_encoding_width
      $error("encoding_width %0d does not match data_width %0d", encoding_width, data_width);
   end
   if (pos_width != $clog2(encoding_width)) begin : g_bad_pos_width
      $error("pos_width %0d does not match encoding_width %0d", pos_width, encoding_width);
   end

   // Bits of the codeword covered by the parity bit at position 2^k.
   function automatic logic [encoding_width-1:0] parity_mask(input int k);
      logic [encoding_width-1:0] m;
      m = '0;
      for (int i = encoding_width - 1; i >= 0; i--)
         m = {m[encoding_width-2:0], (((i + 1) >> k) & 1) == 1};
      return m;
   endfunction

   function automatic logic [encoding_width-1:0] encode(input logic [data_width-1:0] d);
      logic [encoding_width-1:0] cw;
      logic [data_width-1:0]     dsh;
      logic                      par;
      cw  = '0;
      dsh = d;
      // Data fills non-power-of-two positions in ascending order.
      for (int i = 0; i < encoding_width; i++) begin
         if (((i + 1) & i) != 0) begin
            cw  = {dsh[0], cw[encoding_width-1:1]};
            dsh = dsh >> 1;
         end else begin
            cw  = {1'b0, cw[encoding_width-1:1]};
         end
      end
      for (int k = 0; (1 << k) <= encoding_width; k++) begin
         par = ^(cw & parity_mask(k));
         cw  = cw | ({{(encoding_width-1){1'b0}}, par} << ((1 << k) - 1));
      end
      return cw;
   endfunction

   logic [1:0]                cnt;
   logic [encoding_width-1:0] head;
   logic [encoding_width-1:0] tail;
   logic [encoding_width-1:0] inj_mask;
   logic [encoding_width-1:0] cw_in;
   logic                      push;
   logic                      pop;

   always_comb begin
      inj_mask = '0;
      for (int i = encoding_width - 1; i >= 0; i--)
         inj_mask = {inj_mask[encoding_width-2:0], inj_en && (int'(inj_pos) == i)};
   end

   assign cw_in        = encode(raw_data) ^ inj_mask;
   assign raw_ready    = (cnt < 2'd2);
   assign valid        = (cnt != 2'd0);
   assign encoded_data = head;
   assign push         = raw_valid && raw_ready;
   assign pop          = valid && ready;

   // Buffer head/count; a push alongside a pop can only happen at count 1.
   always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) begin
         cnt        <= 2'd0;
         head       <= '0;
         word_count <= 16'd0;
      end else begin
         if (push) word_count <= word_count + 16'd1;
         case ({push, pop})
            2'b10: begin
               if (cnt == 2'd0) head <= cw_in;
               cnt <= cnt + 2'd1;
            end
            2'b01: begin
               head <= tail;
               cnt  <= cnt - 2'd1;
            end
            2'b11:   head <= cw_in;
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (push && !pop && cnt == 2'd1) tail <= cw_in;
   end

endmodule

// File: tb/tb_hamming_encode.sv
// Directed and randomized round-trip bench for hamming_encode.
module tb_hamming_encode;

   localparam int NWORDS = 70000;

   logic        clk = 1'b0;
   logic        rstb;
   logic [15:0] raw_data;
   logic        raw_valid;
   logic        raw_ready;
   logic        inj_en;
   logic [4:0]  inj_pos;
   logic [20:0] encoded_data;
   logic        valid;
   logic        ready;
   logic [15:0] word_count;

   int nchk  = 0;
   int npass = 0;

   hamming_encode #(.data_width(16), .encoding_width(21), .pos_width(5)) dut (
      .clk(clk), .rstb(rstb), .raw_data(raw_data), .raw_valid(raw_valid),
      .raw_ready(raw_ready), .inj_en(inj_en), .inj_pos(inj_pos),
      .encoded_data(encoded_data), .valid(valid), .ready(ready),
      .word_count(word_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      nchk++;
      if (got === exp) npass++;
      else $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
   endtask

   // Reference SEC decoder: syndrome locates the flipped position.
   function automatic logic [15:0] decode(input logic [20:0] cw_in);
      logic [20:0] cw;
      logic [20:0] sh;
      logic [15:0] d;
      int          s;
      cw = cw_in;
      sh = cw;
      s  = 0;
      for (int i = 0; i < 21; i++) begin
         if (sh[0]) s = s ^ (i + 1);
         sh = sh >> 1;
      end
      if (s != 0 && s <= 21) cw = cw ^ (21'd1 << (s - 1));
      d  = '0;
      sh = cw;
      for (int i = 0; i < 21; i++) begin
         if (((i + 1) & i) != 0) d = {sh[0], d[15:1]};
         sh = sh >> 1;
      end
      return d;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rstb = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rstb = 1'b1;
   endtask

   logic [15:0] q[$];
   logic [15:0] front;
   int          pushed;
   int          popped;
   int          cycles;
   logic        do_push;
   logic        do_pop;

   initial begin
      raw_data = '0; raw_valid = 1'b0; inj_en = 1'b0; inj_pos = '0; ready = 1'b0;
      do_reset();
      chk("rst_valid", 32'(valid), 32'd0);
      chk("rst_enc", 32'(encoded_data), 32'd0);
      chk("rst_wc", 32'(word_count), 32'd0);
      chk("rst_raw_ready", 32'(raw_ready), 32'd1);

      // 1: single word, one-cycle latency
      ready = 1'b1; raw_valid = 1'b1; raw_data = 16'd10;
      step();
      raw_valid = 1'b0;
      chk("t1_valid", 32'(valid), 32'd1);
      chk("t1_enc", 32'(encoded_data), 32'd82);
      chk("t1_wc", 32'(word_count), 32'd1);
      step();
      chk("t1_drain", 32'(valid), 32'd0);

      // 2: back-to-back at full rate
      raw_valid = 1'b1; raw_data = 16'd19008;
      step();
      chk("t2_enc0", 32'(encoded_data), 32'd599040);
      chk("t2_rdy0", 32'(raw_ready), 32'd1);
      raw_data = 16'd0;
      step();
      chk("t2_enc1", 32'(encoded_data), 32'd0);
      chk("t2_vld1", 32'(valid), 32'd1);
      chk("t2_rdy1", 32'(raw_ready), 32'd1);
      raw_data = 16'd1;
      step();
      raw_valid = 1'b0;
      chk("t2_enc2", 32'(encoded_data), 32'd7);
      chk("t2_rdy2", 32'(raw_ready), 32'd1);
      chk("t2_wc", 32'(word_count), 32'd4);
      step();

      // 3: backpressure fills the buffer, then drains in order
      ready = 1'b0; raw_valid = 1'b1; raw_data = 16'd10;
      step();
      chk("t3_rdy_after1", 32'(raw_ready), 32'd1);
      raw_data = 16'd1;
      step();
      chk("t3_rdy_full", 32'(raw_ready), 32'd0);
      chk("t3_head", 32'(encoded_data), 32'd82);
      raw_data = 16'd19008;
      step();
      step();
      chk("t3_rdy_held", 32'(raw_ready), 32'd0);
      chk("t3_wc_held", 32'(word_count), 32'd6);
      chk("t3_head_held", 32'(encoded_data), 32'd82);
      ready = 1'b1;
      step();
      chk("t3_out2", 32'(encoded_data), 32'd7);
      chk("t3_rdy_back", 32'(raw_ready), 32'd1);
      step();
      raw_valid = 1'b0;
      chk("t3_out3", 32'(encoded_data), 32'd599040);
      chk("t3_wc", 32'(word_count), 32'd7);
      step();
      chk("t3_empty", 32'(valid), 32'd0);

      // 4: error injection
      raw_valid = 1'b1; raw_data = 16'd19008; inj_en = 1'b1; inj_pos = 5'd7;
      step();
      chk("t4_pos7", 32'(encoded_data), 32'd599168);
      inj_pos = 5'd6;
      step();
      chk("t4_pos6", 32'(encoded_data), 32'd599104);
      inj_pos = 5'd25;
      step();
      chk("t4_pos25", 32'(encoded_data), 32'd599040);
      inj_en = 1'b0; inj_pos = 5'd7;
      step();
      raw_valid = 1'b0;
      chk("t4_clean", 32'(encoded_data), 32'd599040);
      step();

      // 5: asynchronous reset with the buffer full
      ready = 1'b0; raw_valid = 1'b1; raw_data = 16'd1;
      step();
      step();
      raw_valid = 1'b0;
      chk("t5_pre_valid", 32'(valid), 32'd1);
      #2 rstb = 1'b0;
      #1;
      chk("t5_valid", 32'(valid), 32'd0);
      chk("t5_wc", 32'(word_count), 32'd0);
      chk("t5_enc", 32'(encoded_data), 32'd0);
      @(negedge clk);
      rstb = 1'b1;
      @(posedge clk);
      #1;
      ready = 1'b1; raw_valid = 1'b1; raw_data = 16'd10;
      step();
      raw_valid = 1'b0;
      chk("t5_after", 32'(encoded_data), 32'd82);
      chk("t5_after_wc", 32'(word_count), 32'd1);
      step();

      // 6: random traffic round-tripped through the reference decoder
      do_reset();
      raw_valid = 1'b0; inj_en = 1'b0;
      pushed = 0; popped = 0; cycles = 0;
      while (popped < NWORDS && cycles < 95000) begin
         if (!raw_valid && pushed < NWORDS &&
             (pushed >= 3000 || $urandom_range(9) < 7)) begin
            raw_valid = 1'b1;
            raw_data  = 16'($urandom);
            inj_en    = 1'($urandom_range(1));
            inj_pos   = 5'($urandom_range(31));
         end
         ready   = (pushed >= 3000) ? 1'b1 : ($urandom_range(9) < 7);
         do_push = raw_valid && raw_ready;
         do_pop  = valid && ready;
         if (do_pop) begin
            if (q.size() == 0) begin
               chk("rt_unexpected_pop", 32'd1, 32'd0);
            end else begin
               front = q.pop_front();
               chk("rt_word", 32'(decode(encoded_data)), 32'(front));
            end
            popped++;
         end
         if (do_push) q.push_back(raw_data);
         step();
         cycles++;
         if (do_push) begin
            pushed++;
            raw_valid = 1'b0;
            inj_en    = 1'b0;
         end
      end
      chk("rt_popped", 32'(popped), 32'(NWORDS));
      chk("rt_wc_wrap", 32'(word_count), 32'd4464);

      $display("%0d/%0d checks passed", npass, nchk);
      $finish;
   end

endmodule
